vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator and pixel output stage. Derives a pixel-rate tick from the system clock, runs horizontal and vertical counters, and publishes the current pixel coordinate to the upstream frame source. It registers hsync, vsync and blanked RGB toward the connector. Successor to the fixed 640x480, 1-bit, no-reset VGA driver: adds configurable timings, sync polarity, colour depth, clock division, run enable, reset and frame/line markers.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FPORCH, 16, horizontal front porch (pixels)
H_SYNCPULSE, 96, hsync pulse width (pixels)
H_BPORCH, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FPORCH, 10, vertical front porch (lines)
V_SYNCPULSE, 2, vsync pulse width (lines)
V_BPORCH, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync
COLOR_W, 1, bits per colour channel
CLK_DIV, 2, clk cycles per pixel (>=1; 2 gives 25 MHz from 50 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low freezes timing
r_in  in  COLOR_W  red for pixel (x,y), valid same cycle
g_in  in  COLOR_W  green for pixel (x,y)
b_in  in  COLOR_W  blue for pixel (x,y)
x  out  HW  current horizontal count, HW = clog2(H_TOTAL)
y  out  VW  current vertical count, VW = clog2(V_TOTAL)
active  out  1  (x,y) lies in visible region
hsync  out  1  registered horizontal sync
vsync  out  1  registered vertical sync
r  out  COLOR_W  registered red, zero when blanked
g  out  COLOR_W  registered green
b  out  COLOR_W  registered blue
line_start  out  1  one-clk pulse as pixel x=0 is registered
frame_start  out  1  one-clk pulse as pixel (0,0) is registered

Behaviour:
- H_TOTAL = H_DISPLAY+H_FPORCH+H_SYNCPULSE+H_BPORCH; V_TOTAL likewise.
- Line order: display [0,H_DISPLAY), front porch, sync [H_DISPLAY+H_FPORCH, H_DISPLAY+H_FPORCH+H_SYNCPULSE), back porch. Vertical order is the same, in lines.
- Reset (async, rst_n=0):
  - div_cnt=0, h_cnt=0, v_cnt=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - r,g,b=0; line_start=0, frame_start=0.
  - Mid-frame reset restarts at (0,0) with no partial-line recovery.
- Tick:
  - div_cnt counts 0..CLK_DIV-1 while en=1.
  - tick = en && div_cnt==CLK_DIV-1. CLK_DIV=1 gives tick = en.
  - en=0 holds div_cnt, counters and all registered outputs.
- x=h_cnt, y=v_cnt and active=(h_cnt<H_DISPLAY && v_cnt<V_DISPLAY) are combinational from the counters.
- On tick, in one clk edge:
  - hsync <= HSYNC_POL if h_cnt is in the H sync window, else ~HSYNC_POL.
  - vsync <= VSYNC_POL if v_cnt is in the V sync window, else ~VSYNC_POL. vsync changes only at line granularity.
  - {r,g,b} <= active ? {r_in,g_in,b_in} : 0.
  - line_start <= (h_cnt==0); frame_start <= (h_cnt==0 && v_cnt==0).
  - h_cnt advances; at H_TOTAL-1 it wraps to 0 and v_cnt advances. v_cnt wraps to 0 after V_TOTAL-1.
- Off tick: line_start and frame_start <= 0, so the pulses are exactly one clk wide. Other outputs hold.
- Latency: registered outputs lag x/y by exactly one tick. Sync and colour stay mutually aligned.
- Wrap is simultaneous: at (H_TOTAL-1, V_TOTAL-1) both counters return to 0 on the same tick.

Test Plan:
Common test parameters: H 8/2/3/1 (H_TOTAL 14), V 4/1/2/1 (V_TOTAL 8), CLK_DIV=1, COLOR_W=2, en=1 unless stated.
1. Reset: hold rst_n=0 -> x=0, y=0, hsync=1, vsync=1, rgb=0, pulses 0. Release -> first clk gives frame_start=1, line_start=1, then both return to 0.
2. Horizontal timing: hsync is low for exactly 3 clks, registered from h_cnt=10..12. line_start recurs every 14 clks. active is high for h_cnt 0..7 only.
3. Full frame: frame_start period = 112 clks. vsync is low for 28 clks, covering lines 5..6. Wrap (13,7)->(0,0) occurs in a single clk.
4. Blanking and latency: drive r_in=g_in=b_in=3 constantly -> rgb=3 for 8 clks per visible line, starting 1 clk after x=0, and 0 elsewhere, including all of lines 4..7.
5. Enable and divider: CLK_DIV=2, toggle en low for 5 clks mid-line -> x and outputs frozen during the stall. Each pixel is held for 2 clks. Line period = 28 clks plus stall length. HSYNC_POL=1 build -> hsync idles 0 and pulses 1.
6. Reset mid-frame: assert rst_n at (6,3) for 2 clks -> outputs immediately return to reset values asynchronously, and timing restarts at (0,0) with frame_start.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate tick, h/v counters, registered sync and blanked colour.
// x/y/active are combinational from the counters; registered outputs trail them by one tick.
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FPORCH    = 16,
    parameter int unsigned H_SYNCPULSE = 96,
    parameter int unsigned H_BPORCH    = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_FPORCH    = 10,
    parameter int unsigned V_SYNCPULSE = 2,
    parameter int unsigned V_BPORCH    = 33,
    parameter bit          HSYNC_POL   = 1'b0,
    parameter bit          VSYNC_POL   = 1'b0,
    parameter int unsigned COLOR_W     = 1,
    parameter int unsigned CLK_DIV     = 2,
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FPORCH + H_SYNCPULSE + H_BPORCH,
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FPORCH + V_SYNCPULSE + V_BPORCH,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic [HW-1:0]      x,
    output logic [VW-1:0]      y,
    output logic               active,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned H_SYNC_START = H_DISPLAY + H_FPORCH;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNCPULSE;
    localparam int unsigned V_SYNC_START = V_DISPLAY + V_FPORCH;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNCPULSE;
    localparam int unsigned DW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0]      div_q, div_d;
    logic [HW-1:0]      h_q, h_d;
    logic [VW-1:0]      v_q, v_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic [COLOR_W-1:0] r_q, r_d;
    logic [COLOR_W-1:0] g_q, g_d;
    logic [COLOR_W-1:0] b_q, b_d;
    logic               line_q, line_d;
    logic               frame_q, frame_d;

    logic tick_c, h_last_c, v_last_c, active_c, h_win_c, v_win_c;

    // Decode of the current raster position; compared at 32 bits so sync-window ends never truncate.
    always_comb begin
        tick_c   = en && (32'(div_q) == CLK_DIV - 1);
        h_last_c = (32'(h_q) == H_TOTAL - 1);
        v_last_c = (32'(v_q) == V_TOTAL - 1);
        active_c = (32'(h_q) < H_DISPLAY) && (32'(v_q) < V_DISPLAY);
        h_win_c  = (32'(h_q) >= H_SYNC_START) && (32'(h_q) < H_SYNC_END);
        v_win_c  = (32'(v_q) >= V_SYNC_START) && (32'(v_q) < V_SYNC_END);
    end

    // Next state: everything advances on tick; markers drop on any non-tick cycle.
    always_comb begin
        div_d   = div_q;
        h_d     = h_q;
        v_d     = v_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        line_d  = 1'b0;
        frame_d = 1'b0;

        if (en) begin
            div_d = tick_c ? '0 : div_q + DW'(1);
        end

        if (tick_c) begin
            hsync_d = h_win_c ? HSYNC_POL : ~HSYNC_POL;
            vsync_d = v_win_c ? VSYNC_POL : ~VSYNC_POL;
            r_d     = active_c ? r_in : '0;
            g_d     = active_c ? g_in : '0;
            b_d     = active_c ? b_in : '0;
            line_d  = (h_q == '0);
            frame_d = (h_q == '0) && (v_q == '0);
            if (h_last_c) begin
                h_d = '0;
                v_d = v_last_c ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign x           = h_q;
    assign y           = v_q;
    assign active      = active_c;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two builds (div 1 active-low syncs, div 2 active-high syncs)
// checked each cycle against a tick-count raster model, plus hand-computed timing pins.
module tb_vga_timing_gen;

    localparam int HT = 14;   // 8+2+3+1
    localparam int VT = 8;    // 4+1+2+1

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic       en_v  [2];
    logic [1:0] rin_v [2];
    logic [1:0] gin_v [2];
    logic [1:0] bin_v [2];

    logic [3:0] x0, x1;
    logic [2:0] y0, y1;
    logic       act0, act1, hs0, hs1, vs0, vs1, ls0, ls1, fs0, fs1;
    logic [1:0] r0, g0, b0, r1, g1, b1;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FPORCH(2), .H_SYNCPULSE(3), .H_BPORCH(1),
        .V_DISPLAY(4), .V_FPORCH(1), .V_SYNCPULSE(2), .V_BPORCH(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(2), .CLK_DIV(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en_v[0]),
        .r_in(rin_v[0]), .g_in(gin_v[0]), .b_in(bin_v[0]),
        .x(x0), .y(y0), .active(act0), .hsync(hs0), .vsync(vs0),
        .r(r0), .g(g0), .b(b0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FPORCH(2), .H_SYNCPULSE(3), .H_BPORCH(1),
        .V_DISPLAY(4), .V_FPORCH(1), .V_SYNCPULSE(2), .V_BPORCH(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_W(2), .CLK_DIV(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en_v[1]),
        .r_in(rin_v[1]), .g_in(gin_v[1]), .b_in(bin_v[1]),
        .x(x1), .y(y1), .active(act1), .hsync(hs1), .vsync(vs1),
        .r(r1), .g(g1), .b(b1), .line_start(ls1), .frame_start(fs1)
    );

    function automatic int divs(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic pol(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic int px(input int n);
        return n % HT;
    endfunction

    function automatic int py(input int n);
        return (n / HT) % VT;
    endfunction

    function automatic logic in_act(input int n);
        return (px(n) < 8) && (py(n) < 4);
    endfunction

    // Raster model: n = pixel ticks since reset, ec = enabled clocks since reset.
    int         n_q  [2];
    int         ec_q [2];
    logic       ehs_q[2], evs_q[2], els_q[2], efs_q[2];
    logic [1:0] er_q [2], eg_q[2], eb_q[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                n_q[i]   <= 0;
                ec_q[i]  <= 0;
                ehs_q[i] <= !pol(i);
                evs_q[i] <= !pol(i);
                els_q[i] <= 1'b0;
                efs_q[i] <= 1'b0;
                er_q[i]  <= 2'b0;
                eg_q[i]  <= 2'b0;
                eb_q[i]  <= 2'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (en_v[i]) ec_q[i] <= (ec_q[i] + 1) % divs(i);
                if (en_v[i] && (ec_q[i] == divs(i) - 1)) begin
                    ehs_q[i] <= (px(n_q[i]) >= 10 && px(n_q[i]) < 13) ? pol(i) : !pol(i);
                    evs_q[i] <= (py(n_q[i]) >= 5 && py(n_q[i]) < 7) ? pol(i) : !pol(i);
                    er_q[i]  <= in_act(n_q[i]) ? rin_v[i] : 2'b0;
                    eg_q[i]  <= in_act(n_q[i]) ? gin_v[i] : 2'b0;
                    eb_q[i]  <= in_act(n_q[i]) ? bin_v[i] : 2'b0;
                    els_q[i] <= (px(n_q[i]) == 0);
                    efs_q[i] <= (px(n_q[i]) == 0) && (py(n_q[i]) == 0);
                    n_q[i]   <= (n_q[i] + 1) % (HT * VT);
                end else begin
                    els_q[i] <= 1'b0;
                    efs_q[i] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
        end
    endtask

    task automatic cmp(input int i, input int gx, input int gy, input int ga, input int ghs,
                       input int gvs, input int gr, input int gg, input int gb,
                       input int gls, input int gfs);
        chk($sformatf("d%0d_x", i),      gx,  px(n_q[i]));
        chk($sformatf("d%0d_y", i),      gy,  py(n_q[i]));
        chk($sformatf("d%0d_active", i), ga,  int'(in_act(n_q[i])));
        chk($sformatf("d%0d_hsync", i),  ghs, int'(ehs_q[i]));
        chk($sformatf("d%0d_vsync", i),  gvs, int'(evs_q[i]));
        chk($sformatf("d%0d_r", i),      gr,  int'(er_q[i]));
        chk($sformatf("d%0d_g", i),      gg,  int'(eg_q[i]));
        chk($sformatf("d%0d_b", i),      gb,  int'(eb_q[i]));
        chk($sformatf("d%0d_line", i),   gls, int'(els_q[i]));
        chk($sformatf("d%0d_frame", i),  gfs, int'(efs_q[i]));
    endtask

    // One clock: wait for the falling edge, then compare both builds against the model.
    task automatic step();
        @(negedge clk);
        cmp(0, int'(x0), int'(y0), int'(act0), int'(hs0), int'(vs0),
            int'(r0), int'(g0), int'(b0), int'(ls0), int'(fs0));
        cmp(1, int'(x1), int'(y1), int'(act1), int'(hs1), int'(vs1),
            int'(r1), int'(g1), int'(b1), int'(ls1), int'(fs1));
    endtask

    task automatic set_rgb_all(input logic [1:0] v);
        for (int i = 0; i < 2; i++) begin
            rin_v[i] = v;
            gin_v[i] = v;
            bin_v[i] = v;
        end
    endtask

    initial begin
        int c, c_hs, c_vs, c_rgb3, c_nz, c_ls;

        en_v[0] = 1'b1;
        en_v[1] = 1'b1;
        set_rgb_all(2'd3);

        // Reset held: literal reset values for both builds.
        repeat (3) step();
        chk("rst_x0", int'(x0), 0);
        chk("rst_y0", int'(y0), 0);
        chk("rst_hs0", int'(hs0), 1);
        chk("rst_vs0", int'(vs0), 1);
        chk("rst_rgb0", int'({r0, g0, b0}), 0);
        chk("rst_pulses0", int'({ls0, fs0}), 0);
        chk("rst_hs1_idle", int'(hs1), 0);
        chk("rst_vs1_idle", int'(vs1), 0);

        rst_n = 1'b1;
        step();
        chk("first_frame_start", int'(fs0), 1);
        chk("first_line_start", int'(ls0), 1);
        step();
        chk("frame_start_drop", int'(fs0), 0);
        chk("line_start_drop", int'(ls0), 0);
        chk("x_after_two_ticks", int'(x0), 2);

        // Frame period and per-frame totals for the div-1 build with constant colour 3.
        c = 0;
        while (!fs0 && c < 200) begin step(); c++; end
        chk("frame_start_found", int'(fs0), 1);
        c = 0;
        do begin step(); c++; end while (!fs0 && c < 200);
        chk("frame_period", c, 112);

        c_hs = 0; c_vs = 0; c_rgb3 = 0; c_nz = 0; c_ls = 0;
        for (int k = 0; k < 112; k++) begin
            step();
            if (!hs0) c_hs++;
            if (!vs0) c_vs++;
            if (r0 == 2'd3 && g0 == 2'd3 && b0 == 2'd3) c_rgb3++;
            if ({r0, g0, b0} != 6'd0) c_nz++;
            if (ls0) c_ls++;
        end
        chk("hsync_low_per_frame", c_hs, 24);
        chk("vsync_low_per_frame", c_vs, 28);
        chk("rgb3_per_frame", c_rgb3, 32);
        chk("rgb_nonzero_per_frame", c_nz, 32);
        chk("line_starts_per_frame", c_ls, 8);

        // Divided build: line period with a 5-clock stall, and active-high hsync pulse width.
        c = 0;
        while (!ls1 && c < 100) begin step(); c++; end
        chk("div2_line_found", int'(ls1), 1);
        c = 0;
        repeat (7) begin step(); c++; end
        en_v[1] = 1'b0;
        repeat (5) begin step(); c++; end
        en_v[1] = 1'b1;
        do begin step(); c++; end while (!ls1 && c < 100);
        chk("div2_stalled_line_period", c, 33);
        c_hs = 0;
        for (int k = 0; k < 28; k++) begin
            step();
            if (hs1) c_hs++;
        end
        chk("div2_hsync_high_per_line", c_hs, 6);

        // Randomised enable and colour, checked against the model every clock.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                en_v[i]  = ($urandom_range(0, 3) != 0);
                rin_v[i] = 2'($urandom);
                gin_v[i] = 2'($urandom);
                bin_v[i] = 2'($urandom);
            end
            step();
        end

        // Mid-frame asynchronous reset at (6,3).
        en_v[0] = 1'b1;
        en_v[1] = 1'b1;
        c = 0;
        while (!(x0 == 4'd6 && y0 == 3'd3) && c < 300) begin step(); c++; end
        chk("reached_6_3", int'(x0 == 4'd6 && y0 == 3'd3), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_x", int'(x0), 0);
        chk("async_rst_y", int'(y0), 0);
        chk("async_rst_hs", int'(hs0), 1);
        chk("async_rst_vs", int'(vs0), 1);
        chk("async_rst_rgb", int'({r0, g0, b0}), 0);
        chk("async_rst_pulses", int'({ls0, fs0}), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("restart_frame_start", int'(fs0), 1);
        chk("restart_x", int'(x0), 1);
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
